writeback_queue: RTL and testbench
==================================

// Module: writeback_queue
// PURPOSE
//   Write-back stage directly upstream of the register file. Accepts completed
//   instructions from the memory stage and formats load data (byte/half/word,
//   signed/unsigned, lane-selected). Selects the destination register (rt or rd)
//   and buffers results in a small FIFO. Presents one register-file write per
//   cycle under a valid/ready handshake. Reports pending-write hazards so the
//   read stage can stall.
// PARAMETERS
//   DEPTH   2   queue entries (power of 2, >=2)
//   DATA_W  32  register data width
//   CNT_W   16  width of the retire and misalign counters
// PORTS
//   clk             in   1       clock; all state updates on rising edge
//   rst_n           in   1       asynchronous active-low reset
//   in_valid        in   1       memory stage presents an instruction
//   in_ready        out  1       queue can accept this cycle
//   in_opcode       in   6       primary opcode of the instruction
//   in_rt           in   5       rt field
//   in_rd           in   5       rd field
//   in_reg_dst      in   1       1 = write rd, 0 = write rt
//   in_reg_write    in   1       instruction writes a register
//   in_mem_to_reg   in   1       1 = result from memory, 0 = from ALU
//   in_alu_result   in   DATA_W  ALU result
//   in_mem_data     in   DATA_W  raw aligned memory word
//   in_byte_off     in   2       address bits [1:0] of the load
//   wb_valid        out  1       head entry is valid
//   wb_ready        in   1       register file consumes the head this cycle
//   wb_write_en     out  1       head entry performs a write
//   wb_reg          out  5       destination register of the head entry
//   wb_data         out  DATA_W  formatted write data of the head entry
//   chk_reg_a       in   5       read-stage source register A
//   chk_reg_b       in   5       read-stage source register B
//   hazard_a        out  1       a queued write targets chk_reg_a
//   hazard_b        out  1       a queued write targets chk_reg_b
//   misalign_err    out  1       sticky; set on a misaligned halfword load
//   retire_count    out  CNT_W   entries popped since reset
//   misalign_count  out  CNT_W   misaligned loads since reset
// BEHAVIOUR
//   Reset (async, rst_n=0):
//   - Clear pointers, count, all entry storage, misalign_err and both counters.
//   - All outputs read 0, except in_ready=1.
//   Handshake:
//   - push = in_valid & in_ready; pop = wb_valid & wb_ready.
//   - in_ready = (count < DEPTH). It is registered state only, with no
//     combinational path from wb_ready.
//   - wb_valid = (count != 0). wb_* are driven from the head slot.
//   - Latency is 1 cycle: an entry pushed at edge N is visible on wb_* after N.
//   - Push and pop in the same cycle: count is unchanged, both pointers advance.
//   - Pointers wrap modulo DEPTH. Push when full cannot occur (in_ready=0).
//   Destination select: dest = in_reg_dst ? in_rd : in_rt.
//   Load formatting (in_mem_to_reg=1), computed at push:
//   - Byte lane = in_byte_off; half lane = in_byte_off[1].
//   - 0x20 lb: sign-extend the byte. 0x24 lbu: zero-extend the byte.
//   - 0x21 lh: sign-extend the half. 0x25 lhu: zero-extend the half.
//   - 0x23 lw and any other opcode: the full word.
//   - in_mem_to_reg=0: data = in_alu_result.
//   Misaligned halfword (0x21/0x25 with in_byte_off[0]=1):
//   - The entry is queued with write_en=0.
//   - misalign_err is set and misalign_count increments (saturating).
//   Write enable:
//   - write_en = in_reg_write & (dest != 0) & !misaligned.
//   - Register 0 is never written, but the entry still retires.
//   Hazards:
//   - hazard_x = OR over valid entries of (write_en & reg == chk_reg_x).
//   - The check is combinational over stored entries only; the incoming push
//     is not included.
//   - chk_reg_x == 0 gives hazard_x = 0.
//   retire_count increments on each pop and saturates at all-ones.
//   Reset asserted mid-operation discards queued entries; no write is issued.
// TESTING
//   1. Reset, then push lbu (0x24), mem_data=0x89ABCDEF, off=2, rt=5,
//      reg_dst=0, wb_ready=1 -> next cycle: wb_valid=1, wb_reg=5,
//      wb_data=0x000000AB, wb_write_en=1.
//   2. Push lh (0x21), mem_data=0x8001_7FFF, off=2 -> wb_data=0xFFFF8001.
//      Then off=1 -> wb_write_en=0, misalign_err=1, misalign_count=1.
//   3. Hold wb_ready=0 and push DEPTH entries -> in_ready=0, hazard_a=1 for a
//      queued rd, order preserved. Release wb_ready -> one pop per cycle,
//      retire_count=DEPTH.
//   4. Steady stream with wb_ready=1 and push+pop every cycle -> count stays 1,
//      in_ready stays 1, no entry lost or duplicated across pointer wrap.
//   5. ALU op with reg_dst=1, rd=0, reg_write=1 -> retires with
//      wb_write_en=0; hazard_a=0 for chk_reg_a=0.
//   6. Assert rst_n=0 with 2 entries queued -> wb_valid=0, in_ready=1,
//      counters=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/writeback_queue.sv
// ---------------------------------------------------------------------------
// writeback_queue
//   Write-back stage that sits directly in front of the register file.
//   Completed instructions from the memory stage are formatted (load lane
//   selection plus sign/zero extension), given a destination register
//   (rt or rd), and buffered in a small FIFO. The head of the FIFO is offered
//   to the register file under a valid/ready handshake. The read stage can
//   ask whether any buffered write targets one of its source registers.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   push handshake from the memory stage
//   in_opcode           primary opcode (selects load formatting)
//   in_rt, in_rd        candidate destination fields
//   in_reg_dst          1 = write rd, 0 = write rt
//   in_reg_write        instruction writes a register
//   in_mem_to_reg       1 = result from memory, 0 = ALU result
//   in_alu_result       ALU result
//   in_mem_data         raw aligned memory word
//   in_byte_off         load address bits [1:0]
//   wb_valid/wb_ready   pop handshake toward the register file
//   wb_write_en         head entry performs a write
//   wb_reg, wb_data     destination register and data of the head entry
//   chk_reg_a/b         read-stage source registers to check
//   hazard_a/b          a queued write targets chk_reg_a/b
//   misalign_err        sticky flag for misaligned halfword loads
//   retire_count        entries popped since reset (saturating)
//   misalign_count      misaligned halfword loads since reset (saturating)
// ---------------------------------------------------------------------------
module writeback_queue #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opcode,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic              in_reg_dst,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [1:0]        in_byte_off,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic              wb_write_en,
  output logic [4:0]        wb_reg,
  output logic [DATA_W-1:0] wb_data,
  input  logic [4:0]        chk_reg_a,
  input  logic [4:0]        chk_reg_b,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  retire_count,
  output logic [CNT_W-1:0]  misalign_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [4:0]        reg_q  [DEPTH];
  logic [4:0]        reg_d  [DEPTH];
  logic [DEPTH-1:0]  we_q, we_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  retire_q, retire_d, mis_cnt_q, mis_cnt_d;

  logic              push, pop;
  logic [4:0]        new_reg;
  logic [DATA_W-1:0] new_data;
  logic              new_we, new_misaligned;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [DATA_W-1:0] load_data;
  logic [DEPTH-1:0]  occupied;

  // in_ready depends only on registered occupancy, never on wb_ready.
  assign in_ready = (count_q < DEPTH_C);
  assign wb_valid = (count_q != '0);
  assign push     = in_valid & in_ready;
  assign pop      = wb_valid & wb_ready;

  // Idle outputs read zero so an empty queue never looks like a write.
  assign wb_write_en = wb_valid & we_q[rd_ptr_q];
  assign wb_reg      = wb_valid ? reg_q[rd_ptr_q]  : '0;
  assign wb_data     = wb_valid ? data_q[rd_ptr_q] : '0;

  assign misalign_err   = err_q;
  assign retire_count   = retire_q;
  assign misalign_count = mis_cnt_q;

  // Format the incoming instruction into the entry that would be pushed.
  always_comb begin
    new_reg = in_reg_dst ? in_rd : in_rt;
    case (in_byte_off)
      2'd0:    byte_lane = in_mem_data[7:0];
      2'd1:    byte_lane = in_mem_data[15:8];
      2'd2:    byte_lane = in_mem_data[23:16];
      default: byte_lane = in_mem_data[31:24];
    endcase
    half_lane = in_byte_off[1] ? in_mem_data[31:16] : in_mem_data[15:0];
    case (in_opcode)
      OP_LB:   load_data = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
      OP_LBU:  load_data = {{(DATA_W-8){1'b0}}, byte_lane};
      OP_LH:   load_data = {{(DATA_W-16){half_lane[15]}}, half_lane};
      OP_LHU:  load_data = {{(DATA_W-16){1'b0}}, half_lane};
      default: load_data = in_mem_data;
    endcase
    new_data       = in_mem_to_reg ? load_data : in_alu_result;
    new_misaligned = ((in_opcode == OP_LH) || (in_opcode == OP_LHU)) && in_byte_off[0];
    new_we         = in_reg_write && (new_reg != 5'd0) && !new_misaligned;
  end

  // A slot is live when its distance from the head is below the count;
  // the subtraction wraps naturally because DEPTH is a power of two.
  always_comb begin
    occupied = '0;
    hazard_a = 1'b0;
    hazard_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      occupied[i] = ({1'b0, PTR_W'(i) - rd_ptr_q} < count_q);
      if (occupied[i] && we_q[i] && (chk_reg_a != 5'd0) && (reg_q[i] == chk_reg_a))
        hazard_a = 1'b1;
      if (occupied[i] && we_q[i] && (chk_reg_b != 5'd0) && (reg_q[i] == chk_reg_b))
        hazard_b = 1'b1;
    end
  end

  // Next-state for pointers, storage and the statistics counters.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    data_d    = data_q;
    reg_d     = reg_q;
    we_d      = we_q;
    err_d     = err_q;
    retire_d  = retire_q;
    mis_cnt_d = mis_cnt_q;
    if (push) begin
      data_d[wr_ptr_q] = new_data;
      reg_d[wr_ptr_q]  = new_reg;
      we_d[wr_ptr_q]   = new_we;
      wr_ptr_d         = wr_ptr_q + 1'b1;
      if (new_misaligned) begin
        err_d = 1'b1;
        if (mis_cnt_q != '1) mis_cnt_d = mis_cnt_q + 1'b1;
      end
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      if (retire_q != '1) retire_d = retire_q + 1'b1;
    end
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      we_q      <= '0;
      err_q     <= 1'b0;
      retire_q  <= '0;
      mis_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        reg_q[i]  <= '0;
      end
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      we_q      <= we_d;
      err_q     <= err_d;
      retire_q  <= retire_d;
      mis_cnt_q <= mis_cnt_d;
      data_q    <= data_d;
      reg_q     <= reg_d;
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// ---------------------------------------------------------------------------
// tb_writeback_queue
//   Directed bench for writeback_queue. A queue-based reference model tracks
//   what the register file should see; a compare process checks every output
//   on each falling edge, and literal expectations pin key results.
// ---------------------------------------------------------------------------
module tb_writeback_queue;

  localparam int DEPTH  = 2;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready;
  logic [5:0]        in_opcode;
  logic [4:0]        in_rt, in_rd;
  logic              in_reg_dst, in_reg_write, in_mem_to_reg;
  logic [DATA_W-1:0] in_alu_result, in_mem_data;
  logic [1:0]        in_byte_off;
  logic              wb_valid, wb_ready, wb_write_en;
  logic [4:0]        wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic [4:0]        chk_reg_a, chk_reg_b;
  logic              hazard_a, hazard_b, misalign_err;
  logic [CNT_W-1:0]  retire_count, misalign_count;

  int asserts  = 0;
  int failures = 0;

  writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rt(in_rt), .in_rd(in_rd), .in_reg_dst(in_reg_dst),
    .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
    .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
    .in_byte_off(in_byte_off),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_write_en(wb_write_en),
    .wb_reg(wb_reg), .wb_data(wb_data),
    .chk_reg_a(chk_reg_a), .chk_reg_b(chk_reg_b),
    .hazard_a(hazard_a), .hazard_b(hazard_b),
    .misalign_err(misalign_err), .retire_count(retire_count),
    .misalign_count(misalign_count)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of formatted register-file writes.
  typedef struct {
    bit       we;
    int       rg;
    bit [31:0] data;
  } entry_t;

  entry_t model_q[$];
  int     m_retire;
  int     m_miscnt;
  bit     m_err;

  function automatic entry_t formatEntry();
    entry_t e;
    int     dest;
    bit     mis;
    bit [7:0]  b8;
    bit [15:0] h16;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    int     sv;
    dest = in_reg_dst ? int'(in_rd) : int'(in_rt);
    b8  = 8'(in_mem_data >> (8 * int'(in_byte_off)));
    h16 = 16'(in_mem_data >> (16 * (int'(in_byte_off) / 2)));
    mis = ((in_opcode == 6'h21) || (in_opcode == 6'h25)) && (in_byte_off % 2 == 1);
    e.data = in_mem_data;
    if (in_mem_to_reg) begin
      if (in_opcode == 6'h20) begin sb = b8; sv = sb; e.data = sv; end
      else if (in_opcode == 6'h24) e.data = {24'd0, b8};
      else if (in_opcode == 6'h21) begin sh = h16; sv = sh; e.data = sv; end
      else if (in_opcode == 6'h25) e.data = {16'd0, h16};
    end else begin
      e.data = in_alu_result;
    end
    e.rg = dest;
    e.we = in_reg_write && (dest != 0) && !mis;
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
      m_retire = 0;
      m_miscnt = 0;
      m_err    = 0;
    end else begin
      automatic bit do_push = in_valid && (model_q.size() < DEPTH);
      automatic bit do_pop  = (model_q.size() != 0) && wb_ready;
      automatic entry_t ne  = formatEntry();
      if (do_pop) begin
        void'(model_q.pop_front());
        if (m_retire < 65535) m_retire++;
      end
      if (do_push) begin
        model_q.push_back(ne);
        if (((in_opcode == 6'h21) || (in_opcode == 6'h25)) && in_byte_off[0]) begin
          m_err = 1;
          if (m_miscnt < 65535) m_miscnt++;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    asserts++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit modelHazard(input logic [4:0] r);
    bit h = 0;
    if (r != 0)
      foreach (model_q[i]) if (model_q[i].we && model_q[i].rg == int'(r)) h = 1;
    return h;
  endfunction

  // Compare process: every output against the model on each falling edge.
  always @(negedge clk) begin
    checkOutput("in_ready", in_ready, model_q.size() < DEPTH);
    checkOutput("wb_valid", wb_valid, model_q.size() != 0);
    if (model_q.size() != 0) begin
      checkOutput("wb_write_en", wb_write_en, model_q[0].we);
      checkOutput("wb_reg", wb_reg, model_q[0].rg);
      checkOutput("wb_data", wb_data, model_q[0].data);
    end
    checkOutput("hazard_a", hazard_a, modelHazard(chk_reg_a));
    checkOutput("hazard_b", hazard_b, modelHazard(chk_reg_b));
    checkOutput("misalign_err", misalign_err, m_err);
    checkOutput("retire_count", retire_count, m_retire);
    checkOutput("misalign_count", misalign_count, m_miscnt);
  end

  // Drive one instruction for one clock edge, leaving outputs settled at +1.
  task automatic applyStimulus(input logic [5:0] op, input logic [4:0] rt,
                               input logic [4:0] rd, input logic reg_dst,
                               input logic reg_write, input logic m2r,
                               input logic [31:0] alu, input logic [31:0] mem,
                               input logic [1:0] off);
    in_valid      = 1'b1;
    in_opcode     = op;
    in_rt         = rt;
    in_rd         = rd;
    in_reg_dst    = reg_dst;
    in_reg_write  = reg_write;
    in_mem_to_reg = m2r;
    in_alu_result = alu;
    in_mem_data   = mem;
    in_byte_off   = off;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_opcode = 0; in_rt = 0; in_rd = 0; in_reg_dst = 0;
    in_reg_write = 0; in_mem_to_reg = 0; in_alu_result = 0; in_mem_data = 0;
    in_byte_off = 0; wb_ready = 1; chk_reg_a = 0; chk_reg_b = 0;
    #2;
    checkOutput("reset in_ready", in_ready, 1);
    checkOutput("reset wb_valid", wb_valid, 0);
    checkOutput("reset wb_data", wb_data, 0);
    checkOutput("reset retire_count", retire_count, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Test 1: lbu lane 2.
    applyStimulus(6'h24, 5'd5, 5'd0, 0, 1, 1, 32'h0, 32'h89ABCDEF, 2'd2);
    checkOutput("t1 wb_valid", wb_valid, 1);
    checkOutput("t1 wb_reg", wb_reg, 5);
    checkOutput("t1 wb_data", wb_data, 32'h000000AB);
    checkOutput("t1 wb_write_en", wb_write_en, 1);

    // Test 2: lh upper half, then a misaligned lh.
    applyStimulus(6'h21, 5'd6, 5'd0, 0, 1, 1, 32'h0, 32'h80017FFF, 2'd2);
    checkOutput("t2 lh data", wb_data, 32'hFFFF8001);
    applyStimulus(6'h21, 5'd7, 5'd0, 0, 1, 1, 32'h0, 32'h80017FFF, 2'd1);
    checkOutput("t2 mis write_en", wb_write_en, 0);
    checkOutput("t2 misalign_err", misalign_err, 1);
    checkOutput("t2 misalign_count", misalign_count, 1);

    // Further formatting vectors: lb, lhu, lw, other opcode.
    applyStimulus(6'h20, 5'd8, 5'd0, 0, 1, 1, 32'h0, 32'h00800000, 2'd2);
    checkOutput("lb data", wb_data, 32'hFFFFFF80);
    applyStimulus(6'h25, 5'd9, 5'd0, 0, 1, 1, 32'h0, 32'h80017FFF, 2'd2);
    checkOutput("lhu data", wb_data, 32'h00008001);
    applyStimulus(6'h23, 5'd3, 5'd0, 0, 1, 1, 32'h0, 32'hCAFEF00D, 2'd0);
    checkOutput("lw data", wb_data, 32'hCAFEF00D);
    applyStimulus(6'h0F, 5'd4, 5'd0, 0, 1, 1, 32'h0, 32'h12345678, 2'd3);
    checkOutput("other op data", wb_data, 32'h12345678);
    idleCycles(2);
    checkOutput("drained retire_count", retire_count, 7);

    // Test 3: fill the queue with wb_ready low, then drain it.
    wb_ready = 0;
    chk_reg_a = 5'd10;
    chk_reg_b = 5'd11;
    applyStimulus(6'h00, 5'd1, 5'd10, 1, 1, 0, 32'h1111, 32'h0, 2'd0);
    checkOutput("t3 ready after 1", in_ready, 1);
    applyStimulus(6'h00, 5'd2, 5'd11, 1, 1, 0, 32'h2222, 32'h0, 2'd0);
    checkOutput("t3 full in_ready", in_ready, 0);
    checkOutput("t3 hazard_a", hazard_a, 1);
    checkOutput("t3 hazard_b", hazard_b, 1);
    checkOutput("t3 head reg", wb_reg, 10);
    wb_ready = 1;
    idleCycles(1);
    checkOutput("t3 second reg", wb_reg, 11);
    checkOutput("t3 second data", wb_data, 32'h2222);
    checkOutput("t3 hazard_a cleared", hazard_a, 0);
    idleCycles(1);
    checkOutput("t3 retire_count", retire_count, 7 + DEPTH);
    chk_reg_a = 0;
    chk_reg_b = 0;

    // Test 4: continuous push with pop across several pointer wraps.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(6'h00, 5'd0, 5'(12 + k), 1, 1, 0, 32'hA000 + k, 32'h0, 2'd0);
      in_valid = (k < 5);
      checkOutput("t4 in_ready", in_ready, 1);
      checkOutput("t4 stream data", wb_data, 32'hA000 + k);
    end
    in_valid = 0;
    idleCycles(1);
    checkOutput("t4 retire_count", retire_count, 9 + 6);

    // Test 5: write to register 0 retires without a write.
    chk_reg_a = 0;
    applyStimulus(6'h00, 5'd0, 5'd0, 1, 1, 0, 32'hDEAD, 32'h0, 2'd0);
    checkOutput("t5 wb_valid", wb_valid, 1);
    checkOutput("t5 write_en", wb_write_en, 0);
    checkOutput("t5 hazard_a", hazard_a, 0);
    idleCycles(1);

    // Test 6: asynchronous reset with two entries queued.
    wb_ready = 0;
    applyStimulus(6'h00, 5'd0, 5'd20, 1, 1, 0, 32'h1, 32'h0, 2'd0);
    applyStimulus(6'h00, 5'd0, 5'd21, 1, 1, 0, 32'h2, 32'h0, 2'd0);
    checkOutput("t6 full before reset", in_ready, 0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t6 wb_valid", wb_valid, 0);
    checkOutput("t6 in_ready", in_ready, 1);
    checkOutput("t6 retire_count", retire_count, 0);
    checkOutput("t6 misalign_count", misalign_count, 0);
    checkOutput("t6 misalign_err", misalign_err, 0);
    idleCycles(2);
    rst_n = 1'b1;
    idleCycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
